// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the registered round-robin stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Index width for n channels, never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producers, the multiplexer and one shared consumer.
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = sel_w(N_CH);

  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SEL_W-1:0]      out_sel;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel, busy
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational arbiter: lowest requester at or above the pointer wins, wrapping to 0.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] pointer,
  input  logic             fixed,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [N_CH-1:0] upper_mask;
  logic [N_CH-1:0] upper_req;
  logic [N_CH-1:0] pick_from;

  // Fixed priority is round-robin with the search window opened to every channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      upper_mask[i] = fixed || (i >= int'(pointer));
    end
  end

  assign upper_req = req & upper_mask;
  assign pick_from = (|upper_req) ? upper_req : req;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant     = '0;
    grant_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pick_from[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-aware stream multiplexer with a registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 0
) (
  input logic            clk,
  input logic            rst_n,
  stream_mux_rr_if.slave bus
);

  localparam int SEL_W = sel_w(N_CH);
  localparam bit FIXED = (MODE == int'(MODE_FIXED));

  state_e           state_q,     state_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;
  logic [SEL_W-1:0] lock_ch_q,   lock_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;

  logic             can_load;
  logic             xfer;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;

  assign can_load = !out_valid_q || bus.out_ready;

  // A held lock narrows the request set to the owning channel; others wait.
  assign req = (state_q == ST_LOCKED) ? (bus.in_valid & (N_CH'(1) << lock_ch_q))
                                      : bus.in_valid;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (req),
    .pointer   (ptr_q),
    .fixed     (FIXED),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // No handshake may complete while reset is held.
  assign bus.in_ready = (can_load && rst_n) ? grant : '0;
  assign xfer         = can_load && (|grant);

  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        beat_data = bus.in_data[i*WIDTH +: WIDTH];
        beat_last = bus.in_last[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (can_load) out_valid_d = xfer;

    if (xfer) begin
      out_data_d = beat_data;
      out_last_d = beat_last;
      out_sel_d  = grant_idx;
      if (beat_last) begin
        state_d = ST_IDLE;
        // Pointer advances per packet, not per beat.
        if (!FIXED) ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_stream_mux_rr.sv
// Drives a round-robin and a fixed-priority instance against a packet-level reference model.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = sel_w(N);

  typedef struct packed {
    logic [31:0]   cyc;
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
    logic          last;
    logic          busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_mux_rr_if #(.N_CH(N), .WIDTH(W)) bus_rr ();
  stream_mux_rr_if #(.N_CH(N), .WIDTH(W)) bus_fx ();

  stream_mux_rr #(.N_CH(N), .WIDTH(W), .MODE(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
  stream_mux_rr #(.N_CH(N), .WIDTH(W), .MODE(1)) dut_fx (.clk(clk), .rst_n(rst_n), .bus(bus_fx.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Index 0 is the round-robin instance, index 1 the fixed-priority one.
  logic [W:0]       chq [2][N][$];
  obs_t             obs_q [2][$];
  bit               en [N];
  int               vprob, rprob;

  logic [N-1:0]     d_val [2];
  logic [N*W-1:0]   d_data [2];
  logic [N-1:0]     d_last [2];
  logic             d_ordy [2];

  logic [N-1:0]     s_rdy [2];
  logic             s_ov [2], s_ol [2], s_busy [2];
  logic [W-1:0]     s_od [2];
  logic [SW-1:0]    s_os [2];

  bit               m_ov [2], m_ol [2], m_can [2];
  logic [W-1:0]     m_od [2];
  int               m_os [2], m_lock [2], m_ptr [2], m_grant [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    bus_rr.in_valid = d_val[0]; bus_rr.in_data = d_data[0];
    bus_rr.in_last  = d_last[0]; bus_rr.out_ready = d_ordy[0];
    bus_fx.in_valid = d_val[1]; bus_fx.in_data = d_data[1];
    bus_fx.in_last  = d_last[1]; bus_fx.out_ready = d_ordy[1];
  endtask

  task automatic sample();
    s_rdy[0] = bus_rr.in_ready; s_ov[0] = bus_rr.out_valid; s_od[0] = bus_rr.out_data;
    s_ol[0]  = bus_rr.out_last; s_os[0] = bus_rr.out_sel;   s_busy[0] = bus_rr.busy;
    s_rdy[1] = bus_fx.in_ready; s_ov[1] = bus_fx.out_valid; s_od[1] = bus_fx.out_data;
    s_ol[1]  = bus_fx.out_last; s_os[1] = bus_fx.out_sel;   s_busy[1] = bus_fx.busy;
  endtask

  task automatic zero_inputs();
    for (int m = 0; m < 2; m++) begin
      d_val[m] = '0; d_data[m] = '0; d_last[m] = '0; d_ordy[m] = 1'b0;
    end
    apply();
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ov[m] = 1'b0; m_ol[m] = 1'b0; m_od[m] = '0; m_os[m] = 0;
      m_lock[m] = -1; m_ptr[m] = 0; m_grant[m] = -1;
      for (int c = 0; c < N; c++) chq[m][c].delete();
    end
  endtask

  task automatic drive_inputs();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < N; c++) begin
        if (en[c] && chq[m][c].size() > 0 && $urandom_range(99) < vprob) begin
          d_val[m][c] = 1'b1;
          {d_last[m][c], d_data[m][c*W +: W]} = chq[m][c][0];
        end else begin
          d_val[m][c] = 1'b0;
          d_last[m][c] = 1'($urandom);
          d_data[m][c*W +: W] = W'($urandom);
        end
      end
      d_ordy[m] = ($urandom_range(99) < rprob);
    end
    apply();
  endtask

  // Who may be granted this cycle, straight from the arbitration rules.
  task automatic model_comb(input int m);
    int start;
    m_can[m]   = !m_ov[m] || d_ordy[m];
    m_grant[m] = -1;
    start      = (m == 1) ? 0 : m_ptr[m];
    if (m_can[m]) begin
      if (m_lock[m] >= 0) begin
        if (d_val[m][m_lock[m]]) m_grant[m] = m_lock[m];
      end else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (start + k) % N;
          if (m_grant[m] < 0 && d_val[m][c]) m_grant[m] = c;
        end
      end
    end
  endtask

  task automatic compare(input int m);
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (m_grant[m] >= 0) exp_rdy[m_grant[m]] = 1'b1;
    check($sformatf("in_ready[%0d]", m), s_rdy[m], exp_rdy);
    check($sformatf("out_valid[%0d]", m), s_ov[m], m_ov[m]);
    check($sformatf("busy[%0d]", m), s_busy[m], (m_lock[m] >= 0));
    if (m_ov[m]) begin
      check($sformatf("out_data[%0d]", m), s_od[m], m_od[m]);
      check($sformatf("out_last[%0d]", m), s_ol[m], m_ol[m]);
      check($sformatf("out_sel[%0d]", m), s_os[m], m_os[m]);
    end
    if (s_ov[m] && d_ordy[m]) obs_q[m].push_back({32'(cyc), s_os[m], s_od[m], s_ol[m], s_busy[m]});
  endtask

  task automatic model_seq(input int m);
    logic [W:0] beat;
    int g;
    g = m_grant[m];
    if (m_can[m]) begin
      if (g >= 0) begin
        beat = chq[m][g].pop_front();
        m_ov[m] = 1'b1; m_od[m] = beat[W-1:0]; m_ol[m] = beat[W]; m_os[m] = g;
        if (beat[W]) begin
          m_lock[m] = -1;
          if (m == 0) m_ptr[m] = (g + 1) % N;
        end else begin
          m_lock[m] = g;
        end
      end else begin
        m_ov[m] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive_inputs();
    #1;
    sample();
    for (int m = 0; m < 2; m++) begin
      model_comb(m);
      compare(m);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_seq(m);
    cyc++;
  endtask

  function automatic bit idle();
    bit r;
    r = 1'b1;
    for (int m = 0; m < 2; m++) begin
      if (m_ov[m]) r = 1'b0;
      for (int c = 0; c < N; c++) if (chq[m][c].size() != 0) r = 1'b0;
    end
    return r;
  endfunction

  task automatic drain(input int bound);
    int k;
    k = 0;
    for (int c = 0; c < N; c++) en[c] = 1'b1;
    vprob = 100; rprob = 100;
    while (!idle() && k < bound) begin
      step();
      k++;
    end
    check("drain_done", idle(), 1'b1);
  endtask

  task automatic push_beat(input int c, input logic last, input logic [W-1:0] data);
    for (int m = 0; m < 2; m++) chq[m][c].push_back({last, data});
  endtask

  task automatic clear_obs();
    for (int m = 0; m < 2; m++) obs_q[m].delete();
  endtask

  task automatic check_obs(input string nm, input int m, input int i, input int sel,
                           input int data, input bit last, input bit busy, input int at);
    if (i < obs_q[m].size()) begin
      check($sformatf("%s[%0d].%0d.sel", nm, m, i),  obs_q[m][i].sel,  sel);
      check($sformatf("%s[%0d].%0d.data", nm, m, i), obs_q[m][i].data, data);
      check($sformatf("%s[%0d].%0d.last", nm, m, i), obs_q[m][i].last, last);
      check($sformatf("%s[%0d].%0d.busy", nm, m, i), obs_q[m][i].busy, busy);
      check($sformatf("%s[%0d].%0d.cyc", nm, m, i),  obs_q[m][i].cyc,  at);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected the bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int rr_sel [8];
    int fx_sel [8];
    int lk_sel [4];
    int lk_bsy [4];
    int lk_dat [4];

    rr_sel = '{0, 1, 2, 3, 0, 1, 2, 3};
    fx_sel = '{0, 0, 1, 1, 2, 2, 3, 3};
    lk_sel = '{1, 1, 1, 0};
    lk_bsy = '{1, 1, 0, 0};
    lk_dat = '{8'h31, 8'h32, 8'h33, 8'h40};

    zero_inputs();
    model_reset();
    clear_obs();
    rst_n = 1'b0;

    // Reset held with random inputs: everything quiet.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        d_val[m]  = N'($urandom);
        d_last[m] = N'($urandom);
        d_ordy[m] = 1'($urandom);
        for (int c = 0; c < N; c++) d_data[m][c*W +: W] = W'($urandom);
      end
      apply();
      #1;
      sample();
      for (int m = 0; m < 2; m++) begin
        check($sformatf("rst_out_valid[%0d]", m), s_ov[m], 1'b0);
        check($sformatf("rst_out_data[%0d]", m), s_od[m], '0);
        check($sformatf("rst_out_sel[%0d]", m), s_os[m], '0);
        check($sformatf("rst_busy[%0d]", m), s_busy[m], 1'b0);
        check($sformatf("rst_in_ready[%0d]", m), s_rdy[m], '0);
      end
    end
    zero_inputs();
    rst_n = 1'b1;
    model_reset();

    for (int c = 0; c < N; c++) en[c] = 1'b1;
    vprob = 100; rprob = 100;

    // Continuous single-beat packets on every channel.
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < N; c++) push_beat(c, 1'b1, W'(16 * c + k));
    clear_obs();
    c0 = cyc;
    repeat (10) step();
    check("rr_count[0]", obs_q[0].size(), 8);
    check("rr_count[1]", obs_q[1].size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_obs("rr", 0, i, rr_sel[i], 16 * rr_sel[i] + i / 4, 1'b1, 1'b0, c0 + 1 + i);
      check_obs("rr", 1, i, fx_sel[i], 16 * fx_sel[i] + i % 2, 1'b1, 1'b0, c0 + 1 + i);
    end
    drain(50);

    // Single beat on channel 2.
    push_beat(2, 1'b1, 8'hA5);
    clear_obs();
    c0 = cyc;
    repeat (3) step();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("single_count[%0d]", m), obs_q[m].size(), 1);
      check_obs("single", m, 0, 2, 8'hA5, 1'b1, 1'b0, c0 + 1);
    end
    drain(50);

    // Three-beat packet on channel 1 holds the output while channel 0 waits.
    push_beat(1, 1'b0, 8'h31);
    push_beat(1, 1'b0, 8'h32);
    push_beat(1, 1'b1, 8'h33);
    push_beat(0, 1'b1, 8'h40);
    en[0] = 1'b0;
    clear_obs();
    c0 = cyc;
    step();
    en[0] = 1'b1;
    repeat (5) step();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("lock_count[%0d]", m), obs_q[m].size(), 4);
      for (int i = 0; i < 4; i++)
        check_obs("lock", m, i, lk_sel[i], lk_dat[i], (i >= 2), lk_bsy[i][0], c0 + 1 + i);
    end
    drain(50);

    // Backpressure: output held for three cycles, then two beats back to back.
    push_beat(0, 1'b1, 8'h11);
    push_beat(0, 1'b1, 8'h22);
    clear_obs();
    step();
    rprob = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        check($sformatf("bp_valid[%0d]", m), s_ov[m], 1'b1);
        check($sformatf("bp_data[%0d]", m), s_od[m], 8'h11);
        check($sformatf("bp_in_ready[%0d]", m), s_rdy[m], '0);
      end
    end
    rprob = 100;
    c0 = cyc;
    repeat (3) step();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("bp_count[%0d]", m), obs_q[m].size(), 2);
      check_obs("bp", m, 0, 0, 8'h11, 1'b1, 1'b0, c0);
      check_obs("bp", m, 1, 0, 8'h22, 1'b1, 1'b0, c0 + 1);
    end
    drain(50);

    // Channels 3 and 1 together: channel 1 first (fixed: lowest; RR: pointer sits at 1).
    push_beat(3, 1'b1, 8'h73);
    push_beat(1, 1'b1, 8'h71);
    clear_obs();
    c0 = cyc;
    repeat (4) step();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("fix_count[%0d]", m), obs_q[m].size(), 2);
      check_obs("fix", m, 0, 1, 8'h71, 1'b1, 1'b0, c0 + 1);
      check_obs("fix", m, 1, 3, 8'h73, 1'b1, 1'b0, c0 + 2);
    end
    drain(50);

    // Reset in the middle of a packet.
    for (int b = 0; b < 4; b++) push_beat(2, (b == 3), W'(8'h81 + b));
    repeat (3) step();
    for (int m = 0; m < 2; m++) check($sformatf("pre_rst_busy[%0d]", m), s_busy[m], 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    sample();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("mid_rst_busy[%0d]", m), s_busy[m], 1'b0);
      check($sformatf("mid_rst_valid[%0d]", m), s_ov[m], 1'b0);
      check($sformatf("mid_rst_in_ready[%0d]", m), s_rdy[m], '0);
    end
    zero_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_beat(3, 1'b1, 8'h93);
    push_beat(1, 1'b1, 8'h91);
    clear_obs();
    c0 = cyc;
    repeat (4) step();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("post_rst_count[%0d]", m), obs_q[m].size(), 2);
      check_obs("post_rst", m, 0, 1, 8'h91, 1'b1, 1'b0, c0 + 1);
    end
    drain(50);

    // Random traffic: packets of 1-4 beats, random valid gaps and backpressure.
    vprob = 75; rprob = 70;
    for (int k = 0; k < 3000; k++) begin
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < N; c++)
          if (chq[m][c].size() == 0 && $urandom_range(3) == 0) begin
            int len;
            len = int'($urandom_range(4, 1));
            for (int b = 0; b < len; b++) chq[m][c].push_back({(b == len - 1), W'($urandom)});
          end
      if (k % 500 == 250) rprob = int'($urandom_range(90, 20));
      step();
    end
    drain(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
